im_fetch_unit: RTL and testbench

//  Synchronous, parametrised instruction memory with a valid/ready fetch port. Replaces the

---
 rtl/im_fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_im_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_fetch_unit.sv
// Synchronous instruction memory with a valid/ready fetch port, configurable read latency,
// a credit-limited response buffer, flush for branch redirects and a program-load write port.
module im_fetch_unit #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    DEPTH_LOG2   = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 'h0000_3000,
  parameter int                    READ_LATENCY = 1,
  parameter int                    RSP_DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [0:DATA_WIDTH-1] rsp_data,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_err,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [0:DATA_WIDTH-1] wr_data
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int STAGES = READ_LATENCY - 1;
  localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam int INF_W  = $clog2(READ_LATENCY + 1);
  localparam int SUM_W  = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(4) << DEPTH_LOG2;

  logic [0:DATA_WIDTH-1] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] req_off;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  req_err;
  logic [0:DATA_WIDTH-1] req_word;
  logic                  accept;

  logic [ADDR_WIDTH-1:0] wr_off;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic                  wr_ok;

  logic                  push;
  logic [0:DATA_WIDTH-1] push_data;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic                  push_err;
  logic [INF_W-1:0]      inflight;

  logic [0:DATA_WIDTH-1] buf_data [RSP_DEPTH];
  logic [ADDR_WIDTH-1:0] buf_addr [RSP_DEPTH];
  logic [RSP_DEPTH-1:0]  buf_err;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      buf_count;
  logic                  pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Addresses below BASE_ADDR wrap to huge offsets and fall out of range naturally.
  assign req_off  = req_addr - BASE_ADDR;
  assign req_idx  = req_off[DEPTH_LOG2+1:2];
  assign req_err  = (req_addr[1:0] != 2'b00) || ({1'b0, req_off} >= LIMIT);
  assign req_word = req_err ? '0 : mem[req_idx];

  assign wr_off = wr_addr - BASE_ADDR;
  assign wr_idx = wr_off[DEPTH_LOG2+1:2];
  assign wr_ok  = (wr_addr[1:0] == 2'b00) && ({1'b0, wr_off} >= LIMIT) == 1'b0;

  assign req_ready = !flush && ((SUM_W'(inflight) + SUM_W'(buf_count)) < SUM_W'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;

  // A same-edge fetch sees the pre-write word because the read is taken before this update.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      mem[wr_idx] <= wr_data;
    end
  end

  generate
    if (STAGES == 0) begin : g_direct
      assign push      = accept;
      assign push_data = req_word;
      assign push_addr = req_addr;
      assign push_err  = req_err;
      assign inflight  = '0;
    end else begin : g_pipe
      logic [STAGES-1:0]     st_valid;
      logic [0:DATA_WIDTH-1] st_data [STAGES];
      logic [ADDR_WIDTH-1:0] st_addr [STAGES];
      logic [STAGES-1:0]     st_err;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          st_valid <= '0;
        end else if (flush) begin
          st_valid <= '0;
        end else begin
          st_valid[0] <= accept;
          for (int i = 1; i < STAGES; i++) begin
            st_valid[i] <= st_valid[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        st_data[0] <= req_word;
        st_addr[0] <= req_addr;
        st_err[0]  <= req_err;
        for (int i = 1; i < STAGES; i++) begin
          st_data[i] <= st_data[i-1];
          st_addr[i] <= st_addr[i-1];
          st_err[i]  <= st_err[i-1];
        end
      end

      always_comb begin
        inflight = '0;
        for (int i = 0; i < STAGES; i++) begin
          inflight = inflight + INF_W'(st_valid[i]);
        end
      end

      assign push      = st_valid[STAGES-1];
      assign push_data = st_data[STAGES-1];
      assign push_addr = st_addr[STAGES-1];
      assign push_err  = st_err[STAGES-1];
    end
  endgenerate

  assign pop = rsp_valid && rsp_ready;

  // Credits bound the buffer occupancy, so push never needs an overflow guard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_count <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop) begin
        buf_count <= buf_count + CNT_W'(1);
      end else if (pop && !push) begin
        buf_count <= buf_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= push_data;
      buf_addr[wr_ptr] <= push_addr;
      buf_err[wr_ptr]  <= push_err;
    end
  end

  assign rsp_valid = (buf_count != '0);
  assign rsp_data  = rsp_valid ? buf_data[rd_ptr] : '0;
  assign rsp_addr  = rsp_valid ? buf_addr[rd_ptr] : '0;
  assign rsp_err   = rsp_valid ? buf_err[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_im_fetch_unit.sv
// Scoreboard bench for im_fetch_unit: one instance with READ_LATENCY=1 and one with 3,
// sharing the clock, reset and program-load write port.
module tb_im_fetch_unit;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [0:31] rsp_data  [2];
  logic [31:0] rsp_addr  [2];
  logic        rsp_err   [2];
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [0:31] wr_data;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   w;

  im_fetch_unit #(.READ_LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .flush(flush[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .rsp_addr(rsp_addr[0]), .rsp_err(rsp_err[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  im_fetch_unit #(.READ_LATENCY(3)) dut_l3 (
    .clk(clk), .rst_n(rst_n), .flush(flush[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .rsp_addr(rsp_addr[1]), .rsp_err(rsp_err[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Present one fetch and hold it until accepted; returns the cycles spent waiting for ready.
  task automatic applyStimulus(input int d, input logic [31:0] addr, input logic [31:0] exp_data,
                               input logic exp_err, output int waits);
    exp_t e;
    waits        = 0;
    req_valid[d] = 1'b1;
    req_addr[d]  = addr;
    while (!req_ready[d] && waits < 50) begin
      tick();
      waits++;
    end
    if (!req_ready[d]) begin
      checkOutput("req_ready timeout", {31'b0, req_ready[d]}, 32'd1);
    end else begin
      e.data = exp_data;
      e.addr = addr;
      e.err  = exp_err;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      tick();
    end
    req_valid[d] = 1'b0;
  endtask

  task automatic writeWord(input logic [31:0] addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic waitDrain(input int d);
    int cycles = 0;
    int sz;
    sz = (d == 0) ? q0.size() : q1.size();
    while (sz != 0 && cycles < 50) begin
      tick();
      cycles++;
      sz = (d == 0) ? q0.size() : q1.size();
    end
    checkOutput($sformatf("drain dut%0d pending", d), sz, 32'd0);
  endtask

  task automatic monitorOne(input int d);
    exp_t e;
    int   sz;
    sz = (d == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL unexpected rsp dut%0d: got addr %08h data %08h, expected no response",
               d, rsp_addr[d], rsp_data[d]);
    end else begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      checkOutput($sformatf("rsp_data dut%0d @%08h", d, e.addr), rsp_data[d], e.data);
      checkOutput($sformatf("rsp_addr dut%0d", d), rsp_addr[d], e.addr);
      checkOutput($sformatf("rsp_err dut%0d @%08h", d, e.addr), {31'b0, rsp_err[d]}, {31'b0, e.err});
    end
  endtask

  // Responses are compared on the falling edge, where the handshake is stable.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int d = 0; d < 2; d++) begin
        if (rsp_valid[d] === 1'b1 && rsp_ready[d] === 1'b1) monitorOne(d);
      end
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int d = 0; d < 2; d++) begin
      flush[d]     = 1'b0;
      req_valid[d] = 1'b0;
      req_addr[d]  = '0;
      rsp_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    checkOutput("reset rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
    checkOutput("reset rsp_data", rsp_data[0], 32'd0);
    checkOutput("reset rsp_addr", rsp_addr[0], 32'd0);
    checkOutput("reset rsp_err", {31'b0, rsp_err[0]}, 32'd0);
    checkOutput("reset rsp_valid L3", {31'b0, rsp_valid[1]}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post-reset req_ready", {31'b0, req_ready[0]}, 32'd1);
    checkOutput("post-reset req_ready L3", {31'b0, req_ready[1]}, 32'd1);
    tick();

    $display("[TB] program load");
    writeWord(32'h3000, 32'h3860_0005);
    writeWord(32'h3004, 32'h7C08_02A6);
    writeWord(32'h3008, 32'h6000_0000);
    writeWord(32'h3FFC, 32'h4E80_0020);

    $display("[TB] single fetch latency");
    rsp_ready[0] = 1'b1;
    applyStimulus(0, 32'h3000, 32'h3860_0005, 1'b0, w);
    @(negedge clk);
    checkOutput("t1 rsp_valid next cycle", {31'b0, rsp_valid[0]}, 32'd1);
    tick();
    waitDrain(0);

    $display("[TB] back-to-back fetches");
    applyStimulus(0, 32'h3000, 32'h3860_0005, 1'b0, w);
    checkOutput("t2 stall A", w, 32'd0);
    applyStimulus(0, 32'h3004, 32'h7C08_02A6, 1'b0, w);
    checkOutput("t2 stall B", w, 32'd0);
    applyStimulus(0, 32'h3008, 32'h6000_0000, 1'b0, w);
    checkOutput("t2 stall C", w, 32'd0);
    waitDrain(0);

    $display("[TB] back-pressure");
    rsp_ready[0] = 1'b0;
    applyStimulus(0, 32'h3000, 32'h3860_0005, 1'b0, w);
    checkOutput("t3 stall A", w, 32'd0);
    applyStimulus(0, 32'h3004, 32'h7C08_02A6, 1'b0, w);
    checkOutput("t3 stall B", w, 32'd0);
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h3008;
    tick();
    tick();
    checkOutput("t3 req_ready buffer full", {31'b0, req_ready[0]}, 32'd0);
    rsp_ready[0] = 1'b1;
    applyStimulus(0, 32'h3008, 32'h6000_0000, 1'b0, w);
    checkOutput("t3 third accept wait", w, 32'd1);
    waitDrain(0);

    $display("[TB] alignment and range");
    writeWord(32'h3002, 32'hFFFF_FFFF);
    writeWord(32'h4000, 32'hFFFF_FFFF);
    writeWord(32'h2FFC, 32'hFFFF_FFFF);
    applyStimulus(0, 32'h3002, 32'h0, 1'b1, w);
    applyStimulus(0, 32'h2FFC, 32'h0, 1'b1, w);
    applyStimulus(0, 32'h3FFC, 32'h4E80_0020, 1'b0, w);
    applyStimulus(0, 32'h4000, 32'h0, 1'b1, w);
    waitDrain(0);

    $display("[TB] flush with buffered fetch");
    rsp_ready[0] = 1'b0;
    applyStimulus(0, 32'h3000, 32'h3860_0005, 1'b0, w);
    flush[0]     = 1'b1;
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h3008;
    @(negedge clk);
    checkOutput("t5 req_ready during flush", {31'b0, req_ready[0]}, 32'd0);
    tick();
    flush[0]     = 1'b0;
    req_valid[0] = 1'b0;
    q0.delete();
    @(negedge clk);
    checkOutput("t5 rsp_valid after flush", {31'b0, rsp_valid[0]}, 32'd0);
    tick();
    rsp_ready[0] = 1'b1;
    repeat (3) tick();
    applyStimulus(0, 32'h3004, 32'h7C08_02A6, 1'b0, w);
    waitDrain(0);

    $display("[TB] write during fetch");
    wr_en   = 1'b1;
    wr_addr = 32'h3000;
    wr_data = 32'hDEAD_BEEF;
    applyStimulus(0, 32'h3000, 32'h3860_0005, 1'b0, w);
    wr_en   = 1'b0;
    checkOutput("t6 same-cycle accept", w, 32'd0);
    applyStimulus(0, 32'h3000, 32'hDEAD_BEEF, 1'b0, w);
    waitDrain(0);

    $display("[TB] latency 3 instance");
    rsp_ready[1] = 1'b1;
    applyStimulus(1, 32'h3000, 32'hDEAD_BEEF, 1'b0, w);
    @(negedge clk);
    checkOutput("L3 rsp_valid +1", {31'b0, rsp_valid[1]}, 32'd0);
    @(negedge clk);
    checkOutput("L3 rsp_valid +2", {31'b0, rsp_valid[1]}, 32'd0);
    @(negedge clk);
    checkOutput("L3 rsp_valid +3", {31'b0, rsp_valid[1]}, 32'd1);
    tick();
    waitDrain(1);
    applyStimulus(1, 32'h3004, 32'h7C08_02A6, 1'b0, w);
    checkOutput("L3 stall A", w, 32'd0);
    applyStimulus(1, 32'h3008, 32'h6000_0000, 1'b0, w);
    checkOutput("L3 stall B", w, 32'd0);
    applyStimulus(1, 32'h3FFC, 32'h4E80_0020, 1'b0, w);
    checkOutput("L3 credit stall C", w, 32'd2);
    waitDrain(1);

    $display("[TB] flush with fetches in the pipeline");
    applyStimulus(1, 32'h3004, 32'h7C08_02A6, 1'b0, w);
    applyStimulus(1, 32'h3008, 32'h6000_0000, 1'b0, w);
    flush[1] = 1'b1;
    tick();
    flush[1] = 1'b0;
    q1.delete();
    @(negedge clk);
    checkOutput("L3 rsp_valid after flush", {31'b0, rsp_valid[1]}, 32'd0);
    tick();
    repeat (4) tick();
    applyStimulus(1, 32'h3004, 32'h7C08_02A6, 1'b0, w);
    waitDrain(1);

    $display("[TB] reset mid-operation");
    rsp_ready[0] = 1'b0;
    applyStimulus(0, 32'h3000, 32'hDEAD_BEEF, 1'b0, w);
    applyStimulus(0, 32'h3004, 32'h7C08_02A6, 1'b0, w);
    rst_n = 1'b0;
    q0.delete();
    @(negedge clk);
    checkOutput("mid-reset rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
    checkOutput("mid-reset rsp_data", rsp_data[0], 32'd0);
    tick();
    rst_n        = 1'b1;
    rsp_ready[0] = 1'b1;
    repeat (3) tick();
    applyStimulus(0, 32'h3008, 32'h6000_0000, 1'b0, w);
    waitDrain(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
